// File: rtl/csr_pkg.sv
// Shared definitions for the CSR trap/return sequencer: CSR-file indices,
// CSR function encodings, sequencer states, the CSR port bundle and the
// trap-vector target calculation.
package csr_pkg;

    // CSR-file indices (low five bits of the architectural CSR address)
    localparam logic [4:0] IDX_MEPC   = 5'd1;   // 0x341
    localparam logic [4:0] IDX_MCAUSE = 5'd2;   // 0x342
    localparam logic [4:0] IDX_MTVAL  = 5'd3;   // 0x343
    localparam logic [4:0] IDX_MTVEC  = 5'd5;   // 0x305

    // CSR function encodings: func[1]=0 write, 2'b10 set, 2'b11 clear
    localparam logic [2:0] CSR_W = 3'b001;
    localparam logic [2:0] CSR_S = 3'b010;
    localparam logic [2:0] CSR_C = 3'b011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_TVAL,
        ST_R_VEC,
        ST_WAIT_VEC,
        ST_R_EPC,
        ST_WAIT_EPC,
        ST_REDIR
    } state_t;

    // One side of the CSR-file write/read port
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  func;
        logic [31:0] data;
        logic        sel;
    } csr_port_t;

    // Zero-extend a 5-bit CSR-file index onto the 32-bit address bus
    function automatic logic [31:0] idx_addr(input logic [4:0] idx);
        return {27'd0, idx};
    endfunction

    // Trap target: vectored mode only applies to interrupts; the sum wraps at 32 bits
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic [31:0] cause);
        logic [31:0] base;
        base = mtvec & ~32'd3;
        if (mtvec[1:0] == 2'b01 && cause[31])
            return base + {25'd0, cause[4:0], 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/csr_port_mux.sv
// Chooses who drives the CSR-file port: the pipeline (pass-through) or the
// trap sequencer while it owns the port. A pipeline write can be killed
// without taking the port away from the pipeline.
module csr_port_mux
    import csr_pkg::*;
(
    input  logic      seq_own,   // sequencer owns the port
    input  logic      sel_kill,  // suppress the pipeline's write enable
    input  csr_port_t pipe,
    input  csr_port_t seq,
    output csr_port_t port
);

    // Select the port driver and gate the pipeline write enable
    always_comb begin
        // NOTE: port gets a full default before any conditional override, so no
        // path leaves a field unassigned and no latch is inferred.
        port = pipe;
        if (seq_own)
            port = seq;
        else if (sel_kill)
            port.sel = 1'b0;
    end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer. On an exception it records mepc/mcause/mtval in the
// CSR file, reads mtvec and redirects the PC; on mret it reads mepc and
// redirects. It owns the CSR port and stalls the pipeline while busy.
module csr_trap_seq
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic [31:0] pipe_csr_addr,
    input  logic [2:0]  pipe_csr_func,
    input  logic [31:0] pipe_csr_data,
    input  logic        pipe_csr_sel,
    output logic [31:0] csr_addr,
    output logic [2:0]  csr_func,
    output logic [31:0] csr_data,
    output logic        csr_sel,
    input  logic [31:0] csr_rd_data,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    state_t      state;
    state_t      state_next;
    logic [31:0] cause_q;
    logic [31:0] pc_q;
    logic [31:0] tval_q;
    logic [31:0] redirect_pc_q;
    logic        flush_q;
    logic        accept;
    csr_port_t   pipe_port;
    csr_port_t   seq_port;
    csr_port_t   out_port;

    // A request is only taken in IDLE; anything arriving while busy is ignored
    assign accept = (state == ST_IDLE) && (exc_req || mret_req);

    // State register, latched trap info, flush pulse and redirect target
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state         <= ST_IDLE;
            cause_q       <= '0;
            pc_q          <= '0;
            tval_q        <= '0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            state   <= state_next;
            flush_q <= accept;
            if (accept && exc_req) begin
                cause_q <= exc_cause;
                pc_q    <= exc_pc;
                tval_q  <= exc_tval;
            end
            if (state == ST_WAIT_VEC)
                redirect_pc_q <= trap_target(csr_rd_data, cause_q);
            else if (state == ST_WAIT_EPC)
                redirect_pc_q <= csr_rd_data & ~32'd3;
        end
    end

    // Next-state logic and the sequencer's drive of the CSR port
    always_comb begin
        state_next = state;
        seq_port   = '{addr: '0, func: CSR_W, data: '0, sel: 1'b0};
        unique case (state)
            ST_IDLE: begin
                if (exc_req)
                    state_next = ST_W_EPC;
                else if (mret_req)
                    state_next = ST_R_EPC;
            end
            ST_W_EPC: begin
                seq_port.addr = idx_addr(IDX_MEPC);
                seq_port.data = pc_q & ~32'd3;
                seq_port.sel  = 1'b1;
                state_next    = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                seq_port.addr = idx_addr(IDX_MCAUSE);
                seq_port.data = cause_q;
                seq_port.sel  = 1'b1;
                state_next    = ST_W_TVAL;
            end
            ST_W_TVAL: begin
                seq_port.addr = idx_addr(IDX_MTVAL);
                seq_port.data = tval_q;
                seq_port.sel  = 1'b1;
                state_next    = ST_R_VEC;
            end
            ST_R_VEC: begin
                seq_port.addr = idx_addr(IDX_MTVEC);
                state_next    = ST_WAIT_VEC;
            end
            ST_WAIT_VEC: state_next = ST_REDIR;
            ST_R_EPC: begin
                seq_port.addr = idx_addr(IDX_MEPC);
                state_next    = ST_WAIT_EPC;
            end
            ST_WAIT_EPC: state_next = ST_REDIR;
            ST_REDIR:    state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign pipe_port = '{addr: pipe_csr_addr, func: pipe_csr_func,
                         data: pipe_csr_data, sel: pipe_csr_sel};

    // During reset the pipeline keeps the port but can never write through it
    csr_port_mux u_port_mux (
        .seq_own  ((state != ST_IDLE) && !rst),
        .sel_kill (rst || exc_req || mret_req),
        .pipe     (pipe_port),
        .seq      (seq_port),
        .port     (out_port)
    );

    assign csr_addr       = out_port.addr;
    assign csr_func       = out_port.func;
    assign csr_data       = out_port.data;
    assign csr_sel        = out_port.sel;
    assign stall          = (state != ST_IDLE) || exc_req || mret_req;
    assign flush          = flush_q;
    assign redirect_valid = (state == ST_REDIR);
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: a behavioural CSR file answers the port, expected
// CSR writes and redirects are queued with their due cycle when stimulus is
// driven, and a negedge monitor pops and compares them as the DUT acts.
module tb_csr_trap_seq;

    logic        clk;
    logic        rst;
    logic        exc_req;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_req;
    logic [31:0] pipe_csr_addr;
    logic [2:0]  pipe_csr_func;
    logic [31:0] pipe_csr_data;
    logic        pipe_csr_sel;
    logic [31:0] csr_addr;
    logic [2:0]  csr_func;
    logic [31:0] csr_data;
    logic        csr_sel;
    logic [31:0] csr_rd_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } redir_t;

    wr_t    wr_q[$];
    redir_t rd_q[$];
    logic [31:0] mem [32];
    int     cyc = 0;
    int     flush_cyc = -1;
    int     s_lo = 1;
    int     s_hi = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    logic   exp_w;
    logic   exp_r;

    csr_trap_seq dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_req       (mret_req),
        .pipe_csr_addr  (pipe_csr_addr),
        .pipe_csr_func  (pipe_csr_func),
        .pipe_csr_data  (pipe_csr_data),
        .pipe_csr_sel   (pipe_csr_sel),
        .csr_addr       (csr_addr),
        .csr_func       (csr_func),
        .csr_data       (csr_data),
        .csr_sel        (csr_sel),
        .csr_rd_data    (csr_rd_data),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CSR file: write/set/clear on sel, registered read one cycle later
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            csr_rd_data <= '0;
        end else begin
            if (csr_sel) begin
                if (!csr_func[1])     mem[csr_addr[4:0]] <= csr_data;
                else if (!csr_func[0]) mem[csr_addr[4:0]] <= mem[csr_addr[4:0]] | csr_data;
                else                  mem[csr_addr[4:0]] <= mem[csr_addr[4:0]] & ~csr_data;
            end
            csr_rd_data <= mem[csr_addr[4:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_trap(input logic [31:0] vec, input logic [31:0] cause);
        logic [31:0] base;
        base = {vec[31:2], 2'b00};
        if (vec[1:0] == 2'b01 && cause[31])
            return base + 32'(cause[4:0]) * 32'd4;
        return base;
    endfunction

    // Monitor: compare CSR writes, redirects, flush and stall against the scoreboard
    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_w = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            if (csr_sel || exp_w) begin
                check("csr_sel", 32'(csr_sel), 32'(exp_w));
                if (csr_sel && exp_w) begin
                    check("wr_addr", csr_addr, wr_q[0].addr);
                    check("wr_data", csr_data, wr_q[0].data);
                    check("wr_func", 32'(csr_func), 32'h1);
                end
                if (exp_w) void'(wr_q.pop_front());
            end
            exp_r = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            if (redirect_valid || exp_r) begin
                check("redirect_valid", 32'(redirect_valid), 32'(exp_r));
                if (redirect_valid && exp_r)
                    check("redirect_pc", redirect_pc, rd_q[0].pc);
                if (exp_r) void'(rd_q.pop_front());
            end
            if (flush || cyc == flush_cyc)
                check("flush", 32'(flush), 32'(cyc == flush_cyc));
            check("stall", 32'(stall),
                  32'(exc_req || mret_req || (cyc >= s_lo && cyc <= s_hi)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [31:0] addr, input logic [31:0] data);
        pipe_csr_addr = addr;
        pipe_csr_data = data;
        pipe_csr_func = 3'b001;
        pipe_csr_sel  = 1'b1;
        wr_q.push_back('{cyc: cyc, addr: addr, data: data});
        tick();
        pipe_csr_sel = 1'b0;
        tick();
    endtask

    // Run until the queued redirect has been seen, bounded
    task automatic wait_done();
        int n = 0;
        while (rd_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        if (rd_q.size() > 0) begin
            check("timeout", 32'(rd_q.size()), 32'd0);
            rd_q.delete();
            wr_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic do_exc(input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] vec,
                          input logic also_mret, input logic pipe_sel);
        int t = cyc;
        wr_q.push_back('{cyc: t + 1, addr: 32'h1, data: {pc[31:2], 2'b00}});
        wr_q.push_back('{cyc: t + 2, addr: 32'h2, data: cause});
        wr_q.push_back('{cyc: t + 3, addr: 32'h3, data: tval});
        rd_q.push_back('{cyc: t + 6, pc: exp_trap(vec, cause)});
        flush_cyc = t + 1;
        s_lo = t;
        s_hi = t + 6;
        exc_pc    = pc;
        exc_cause = cause;
        exc_tval  = tval;
        exc_req   = 1'b1;
        mret_req  = also_mret;
        if (pipe_sel) begin
            pipe_csr_addr = 32'h5;
            pipe_csr_data = 32'h0000BAD0;
            pipe_csr_func = 3'b001;
            pipe_csr_sel  = 1'b1;
        end
        tick();
        exc_req      = 1'b0;
        mret_req     = 1'b0;
        pipe_csr_sel = 1'b0;
        wait_done();
    endtask

    task automatic do_mret(input logic [31:0] exp_pc);
        int t = cyc;
        rd_q.push_back('{cyc: t + 3, pc: exp_pc});
        flush_cyc = t + 1;
        s_lo = t;
        s_hi = t + 3;
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        wait_done();
    endtask

    initial begin
        int t;
        rst           = 1'b1;
        exc_req       = 1'b0;
        mret_req      = 1'b0;
        exc_cause     = '0;
        exc_pc        = '0;
        exc_tval      = '0;
        pipe_csr_addr = 32'h5;
        pipe_csr_data = 32'h100;
        pipe_csr_func = 3'b001;
        pipe_csr_sel  = 1'b1;

        // Reset state: pipeline write enable is blocked while rst is high
        tick();
        tick();
        check("rst_csr_sel", 32'(csr_sel), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst          = 1'b0;
        pipe_csr_sel = 1'b0;
        tick();

        // Pass-through write of mtvec, then a direct exception
        pipe_write(32'h5, 32'h100);
        check("idle_stall", 32'(stall), 32'd0);
        do_exc(32'h2006, 32'h2, 32'hDEAD, 32'h100, 1'b0, 1'b0);

        // Vectored mtvec: interrupt offsets the target, synchronous exception does not
        pipe_write(32'h5, 32'h101);
        do_exc(32'h4000, 32'h80000007, 32'h11, 32'h101, 1'b0, 1'b0);
        do_exc(32'h4000, 32'h00000007, 32'h0, 32'h101, 1'b0, 1'b0);

        // mret: aligned and misaligned saved mepc
        pipe_write(32'h341, 32'h3000);
        do_mret(32'h3000);
        pipe_write(32'h341, 32'h5006);
        do_mret(32'h5004);

        // Simultaneous exception and mret with a pipeline CSR write in flight
        do_exc(32'h6000, 32'h5, 32'h77, 32'h101, 1'b1, 1'b1);

        // Reset while writing mcause: only mepc gets written, no redirect follows
        t = cyc;
        wr_q.push_back('{cyc: t + 1, addr: 32'h1, data: 32'h7000});
        flush_cyc = t + 1;
        s_lo = t;
        s_hi = t + 2;
        exc_pc    = 32'h7000;
        exc_cause = 32'h3;
        exc_tval  = 32'h55;
        exc_req   = 1'b1;
        tick();
        exc_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_redirect_pc", redirect_pc, 32'd0);
        check("abort_redirect_valid", 32'(redirect_valid), 32'd0);
        check("abort_flush", 32'(flush), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        repeat (8) tick();

        check("wr_q_left", 32'(wr_q.size()), 32'd0);
        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
